// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer
//   Parallel-to-serial front end for the sequence-detector FSMs. A WIDTH-bit word is taken
//   over a valid/ready handshake and shifted out one bit per clock on x. When the next word
//   is offered during the last bit, it is reloaded in that same cycle, so consecutive words
//   stream without an idle gap.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: din[WIDTH-1] goes out first; 0: din[0] goes out first
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   din        parallel word to serialize
//   din_valid  din is presented
//   din_ready  block can accept din this cycle
//   flush      synchronous abort of the word in flight
//   x          serial bit to the detector
//   x_valid    x carries a word bit this cycle
//   word_done  current x is the last bit of the word
//   busy       a word is in flight (same as x_valid)

module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             flush,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CntW-1:0]  cnt;

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] sreg_shifted;

  assign last_bit  = (cnt == '0);
  // Ready only looks at state, cnt and flush so upstream never sees a combinational loop.
  assign din_ready = !flush && ((state == StIdle) || last_bit);
  assign accept    = din_valid && din_ready;

  // Move every bit one place toward the output end, zero-filling behind.
  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
      assign x            = sreg[WIDTH-1];
    end else begin : g_lsb
      assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
      assign x            = sreg[0];
    end
  endgenerate

  assign x_valid   = (state == StShift);
  assign busy      = (state == StShift);
  assign word_done = (state == StShift) && last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= StIdle;
      sreg  <= '0;
      cnt   <= '0;
    end else if (flush) begin
      // Flush wins over any accept; din_ready is already low so nothing is consumed.
      state <= StIdle;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            state <= StShift;
            sreg  <= din;
            cnt   <= CntLoad;
          end
        end
        StShift: begin
          if (!last_bit) begin
            sreg <= sreg_shifted;
            cnt  <= cnt - 1'b1;
          end else if (accept) begin
            // Gapless reload on the last bit of the current word.
            sreg <= din;
            cnt  <= CntLoad;
          end else begin
            // Clearing sreg keeps x at 0 whenever x_valid is low.
            state <= StIdle;
            sreg  <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= StIdle;
          sreg  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
